// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM/WB stage fields in, pipeline control out.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
);
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic              use_rs_id;
    logic              use_rt_id;
    logic              mem_read_ex;
    logic [REG_AW-1:0] rt_ex;
    logic [REG_AW-1:0] rs_ex;
    logic [REG_AW-1:0] rt_ex_src;
    logic              reg_write_mem;
    logic              reg_write_wb;
    logic [REG_AW-1:0] rd_mem;
    logic [REG_AW-1:0] rd_wb;
    logic              redirect_id;

    logic              pc_write;
    logic              if_id_write;
    logic              bubble;
    logic              if_id_flush;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              busy;
    logic [PERF_W-1:0] stall_events;
    logic [PERF_W-1:0] flush_events;

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, mem_read_ex, rt_ex,
               rs_ex, rt_ex_src, reg_write_mem, reg_write_wb, rd_mem, rd_wb,
               redirect_id,
        input  pc_write, if_id_write, bubble, if_id_flush, forward_a,
               forward_b, busy, stall_events, flush_events
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, mem_read_ex, rt_ex,
               rs_ex, rt_ex_src, reg_write_mem, reg_write_wb, rd_mem, rd_wb,
               redirect_id,
        output pc_write, if_id_write, bubble, if_id_flush, forward_a,
               forward_b, busy, stall_events, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall insertion, ID-stage
// redirect flush, EX operand forwarding and saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int PERF_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hif
);
    typedef logic [REG_AW-1:0] reg_t;
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    // Bubbles still owed after the detection cycle itself.
    localparam logic [1:0] STALL_REM = 2'(LOAD_STALL - 1);

    state_t            state;
    logic [1:0]        rem;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic              hz;

    // Load-use hazard: EX load writes a register the ID instruction reads.
    always_comb begin
        hz = hif.mem_read_ex && (hif.rt_ex != reg_t'(0)) &&
             ((hif.use_rs_id && (hif.rs_id == hif.rt_ex)) ||
              (hif.use_rt_id && (hif.rt_id == hif.rt_ex)));
    end

    // Pipeline enables; reset forces the free-running defaults.
    always_comb begin
        hif.pc_write    = 1'b1;
        hif.if_id_write = 1'b1;
        hif.bubble      = 1'b0;
        hif.if_id_flush = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (hz) begin
                        hif.pc_write    = 1'b0;
                        hif.if_id_write = 1'b0;
                        hif.bubble      = 1'b1;
                    end else if (hif.redirect_id) begin
                        hif.if_id_flush = 1'b1;
                    end
                end
                STALL: begin
                    hif.pc_write    = 1'b0;
                    hif.if_id_write = 1'b0;
                    hif.bubble      = 1'b1;
                end
                default: ;
            endcase
        end
        hif.busy = (state != RUN);
    end

    // EX operand forwarding; the younger MEM result wins over WB.
    always_comb begin
        hif.forward_a = 2'b00;
        hif.forward_b = 2'b00;
        if (rst_n) begin
            if (hif.reg_write_mem && hif.rd_mem != reg_t'(0) && hif.rd_mem == hif.rs_ex)
                hif.forward_a = 2'b10;
            else if (hif.reg_write_wb && hif.rd_wb != reg_t'(0) && hif.rd_wb == hif.rs_ex)
                hif.forward_a = 2'b01;
            if (hif.reg_write_mem && hif.rd_mem != reg_t'(0) && hif.rd_mem == hif.rt_ex_src)
                hif.forward_b = 2'b10;
            else if (hif.reg_write_wb && hif.rd_wb != reg_t'(0) && hif.rd_wb == hif.rt_ex_src)
                hif.forward_b = 2'b01;
        end
    end

    // Sequencer and event counters; counters only step on RUN-state decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            rem       <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz) begin
                        if (stall_cnt != '1)
                            stall_cnt <= stall_cnt + PERF_W'(1);
                        if (LOAD_STALL > 1) begin
                            state <= STALL;
                            rem   <= STALL_REM;
                        end
                    end else if (hif.redirect_id) begin
                        if (flush_cnt != '1)
                            flush_cnt <= flush_cnt + PERF_W'(1);
                        state <= FLUSH;
                    end
                end
                STALL: begin
                    rem <= rem - 2'd1;
                    if (rem <= 2'd1) begin
                        state <= RUN;
                        rem   <= 2'd0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign hif.stall_events = stall_cnt;
    assign hif.flush_events = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one LOAD_STALL=1 instance with a narrow
// counter and one LOAD_STALL=3 instance, both fed the same stage fields.
module tb_pipeline_hazard_ctrl;
    typedef struct {
        logic [4:0] rs_id, rt_id, rt_ex, rs_ex, rt_ex_src, rd_mem, rd_wb;
        logic       use_rs_id, use_rt_id, mem_read_ex;
        logic       reg_write_mem, reg_write_wb, redirect_id;
    } in_t;

    typedef struct {
        in_t        in;
        logic       pc;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic clk;
    logic rst_n;
    in_t  cur;
    int   n_cmp;
    int   n_fail;

    // Reference model state, index 0 = LOAD_STALL 1, index 1 = LOAD_STALL 3.
    int   left[2];
    bit   infl[2];
    int   se[2];
    int   fe[2];
    int   ls[2]  = '{1, 3};
    int   smax[2] = '{15, 65535};

    pipeline_hazard_ctrl_if #(.REG_AW(5), .PERF_W(4))  if_a ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .PERF_W(16)) if_b ();

    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .PERF_W(4)) u_ls1 (
        .clk(clk), .rst_n(rst_n), .hif(if_a));
    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .PERF_W(16)) u_ls3 (
        .clk(clk), .rst_n(rst_n), .hif(if_b));

    assign if_a.rs_id = cur.rs_id;          assign if_b.rs_id = cur.rs_id;
    assign if_a.rt_id = cur.rt_id;          assign if_b.rt_id = cur.rt_id;
    assign if_a.use_rs_id = cur.use_rs_id;  assign if_b.use_rs_id = cur.use_rs_id;
    assign if_a.use_rt_id = cur.use_rt_id;  assign if_b.use_rt_id = cur.use_rt_id;
    assign if_a.mem_read_ex = cur.mem_read_ex; assign if_b.mem_read_ex = cur.mem_read_ex;
    assign if_a.rt_ex = cur.rt_ex;          assign if_b.rt_ex = cur.rt_ex;
    assign if_a.rs_ex = cur.rs_ex;          assign if_b.rs_ex = cur.rs_ex;
    assign if_a.rt_ex_src = cur.rt_ex_src;  assign if_b.rt_ex_src = cur.rt_ex_src;
    assign if_a.reg_write_mem = cur.reg_write_mem; assign if_b.reg_write_mem = cur.reg_write_mem;
    assign if_a.reg_write_wb = cur.reg_write_wb;   assign if_b.reg_write_wb = cur.reg_write_wb;
    assign if_a.rd_mem = cur.rd_mem;        assign if_b.rd_mem = cur.rd_mem;
    assign if_a.rd_wb = cur.rd_wb;          assign if_b.rd_wb = cur.rd_wb;
    assign if_a.redirect_id = cur.redirect_id; assign if_b.redirect_id = cur.redirect_id;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t mk(int mr, int rtex, int rsid, int urs, int rtid, int urt,
                               int redir, int rsex, int rtsrc, int rwm, int rdm,
                               int rww, int rdw);
        in_t x;
        x.mem_read_ex = 1'(mr);   x.rt_ex = 5'(rtex);
        x.rs_id = 5'(rsid);       x.use_rs_id = 1'(urs);
        x.rt_id = 5'(rtid);       x.use_rt_id = 1'(urt);
        x.redirect_id = 1'(redir);
        x.rs_ex = 5'(rsex);       x.rt_ex_src = 5'(rtsrc);
        x.reg_write_mem = 1'(rwm); x.rd_mem = 5'(rdm);
        x.reg_write_wb = 1'(rww);  x.rd_wb = 5'(rdw);
        return x;
    endfunction

    function automatic bit ref_hz(in_t x);
        if (!x.mem_read_ex || x.rt_ex == 0) return 0;
        return (x.use_rs_id && x.rs_id == x.rt_ex) || (x.use_rt_id && x.rt_id == x.rt_ex);
    endfunction

    function automatic logic [1:0] ref_fwd(in_t x, logic [4:0] src);
        if (x.reg_write_mem && x.rd_mem != 0 && x.rd_mem == src) return 2'b10;
        if (x.reg_write_wb && x.rd_wb != 0 && x.rd_wb == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; infl[i] = 0; se[i] = 0; fe[i] = 0;
        end
        tick();
        rst_n = 1'b1;
    endtask

    // Checks every output of one instance against the model's current view.
    task automatic check_model(int i);
        logic pc, ifw, b, f, bz;
        logic [1:0] fa, fb;
        int a_pc, a_ifw, a_b, a_f, a_bz, a_fa, a_fb, a_se, a_fe;
        string t;
        t = (i == 0) ? "ls1" : "ls3";
        pc = 1; ifw = 1; b = 0; f = 0; bz = 0; fa = 0; fb = 0;
        if (rst_n) begin
            bz = (left[i] > 0) || infl[i];
            fa = ref_fwd(cur, cur.rs_ex);
            fb = ref_fwd(cur, cur.rt_ex_src);
            if (left[i] > 0) begin
                pc = 0; ifw = 0; b = 1;
            end else if (!infl[i]) begin
                if (ref_hz(cur)) begin
                    pc = 0; ifw = 0; b = 1;
                end else if (cur.redirect_id) begin
                    f = 1;
                end
            end
        end
        if (i == 0) begin
            a_pc = int'(if_a.pc_write); a_ifw = int'(if_a.if_id_write);
            a_b = int'(if_a.bubble); a_f = int'(if_a.if_id_flush); a_bz = int'(if_a.busy);
            a_fa = int'(if_a.forward_a); a_fb = int'(if_a.forward_b);
            a_se = int'(if_a.stall_events); a_fe = int'(if_a.flush_events);
        end else begin
            a_pc = int'(if_b.pc_write); a_ifw = int'(if_b.if_id_write);
            a_b = int'(if_b.bubble); a_f = int'(if_b.if_id_flush); a_bz = int'(if_b.busy);
            a_fa = int'(if_b.forward_a); a_fb = int'(if_b.forward_b);
            a_se = int'(if_b.stall_events); a_fe = int'(if_b.flush_events);
        end
        chk({t, ".pc_write"}, a_pc, int'(pc));
        chk({t, ".if_id_write"}, a_ifw, int'(ifw));
        chk({t, ".bubble"}, a_b, int'(b));
        chk({t, ".if_id_flush"}, a_f, int'(f));
        chk({t, ".busy"}, a_bz, int'(bz));
        chk({t, ".forward_a"}, a_fa, int'(fa));
        chk({t, ".forward_b"}, a_fb, int'(fb));
        chk({t, ".stall_events"}, a_se, se[i]);
        chk({t, ".flush_events"}, a_fe, fe[i]);
    endtask

    // Advances the model across one rising edge.
    task automatic model_step(int i);
        if (!rst_n) begin
            left[i] = 0; infl[i] = 0; se[i] = 0; fe[i] = 0;
        end else if (left[i] > 0) begin
            left[i]--;
        end else if (infl[i]) begin
            infl[i] = 0;
        end else if (ref_hz(cur)) begin
            if (se[i] < smax[i]) se[i]++;
            left[i] = ls[i] - 1;
        end else if (cur.redirect_id) begin
            if (fe[i] < smax[i]) fe[i]++;
            infl[i] = 1;
        end
    endtask

    in_t  idle, hzd, hzd_redir, redir, noisy;
    vec_t tbl[12];

    initial begin
        n_cmp = 0;
        n_fail = 0;
        idle      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hzd       = mk(1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hzd_redir = mk(1, 5, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        redir     = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        noisy     = mk(1, 5, 5, 1, 5, 1, 1, 7, 7, 1, 7, 1, 7);

        tbl[0]  = '{idle, 1, 0, 2'b00, 2'b00};
        tbl[1]  = '{hzd, 0, 1, 2'b00, 2'b00};
        tbl[2]  = '{mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 2'b00, 2'b00};
        tbl[3]  = '{mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, 0, 2'b00, 2'b00};
        tbl[4]  = '{mk(1, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 2'b00, 2'b00};
        tbl[5]  = '{mk(0, 5, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0), 1, 0, 2'b00, 2'b00};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 7), 1, 0, 2'b10, 2'b00};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 7, 1, 7), 1, 0, 2'b01, 2'b00};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 1, 0, 2'b00, 2'b00};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 4, 3, 0, 3, 1, 3), 1, 0, 2'b00, 2'b01};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 9, 1, 2), 1, 0, 2'b10, 2'b10};
        tbl[11] = '{mk(1, 3, 3, 1, 0, 0, 0, 6, 6, 0, 6, 0, 6), 0, 1, 2'b00, 2'b00};

        // Reset state with every input pushing toward activity.
        rst_n = 1'b0;
        cur = noisy;
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; infl[i] = 0; se[i] = 0; fe[i] = 0;
        end
        @(negedge clk);
        check_model(0);
        check_model(1);
        tick();
        rst_n = 1'b1;

        // Single load-use hazard on both stall depths.
        cur = hzd;
        @(negedge clk);
        chk("ls1.c1.pc_write", int'(if_a.pc_write), 0);
        chk("ls1.c1.bubble", int'(if_a.bubble), 1);
        chk("ls1.c1.busy", int'(if_a.busy), 0);
        chk("ls3.c1.bubble", int'(if_b.bubble), 1);
        chk("ls3.c1.busy", int'(if_b.busy), 0);
        tick();
        cur = idle;
        @(negedge clk);
        chk("ls1.c2.pc_write", int'(if_a.pc_write), 1);
        chk("ls1.c2.bubble", int'(if_a.bubble), 0);
        chk("ls1.c2.stall_events", int'(if_a.stall_events), 1);
        chk("ls3.c2.bubble", int'(if_b.bubble), 1);
        chk("ls3.c2.busy", int'(if_b.busy), 1);
        tick();
        @(negedge clk);
        chk("ls3.c3.bubble", int'(if_b.bubble), 1);
        chk("ls3.c3.busy", int'(if_b.busy), 1);
        chk("ls3.c3.pc_write", int'(if_b.pc_write), 0);
        tick();
        @(negedge clk);
        chk("ls3.c4.pc_write", int'(if_b.pc_write), 1);
        chk("ls3.c4.bubble", int'(if_b.bubble), 0);
        chk("ls3.c4.busy", int'(if_b.busy), 0);
        chk("ls3.c4.stall_events", int'(if_b.stall_events), 1);

        // Hazard and redirect together: stall wins, flush follows the stall.
        tick();
        do_reset();
        cur = hzd_redir;
        @(negedge clk);
        chk("prio.c1.bubble", int'(if_b.bubble), 1);
        chk("prio.c1.if_id_flush", int'(if_b.if_id_flush), 0);
        tick();
        cur = redir;
        @(negedge clk);
        chk("prio.c2.if_id_flush", int'(if_b.if_id_flush), 0);
        tick();
        @(negedge clk);
        chk("prio.c3.if_id_flush", int'(if_b.if_id_flush), 0);
        chk("prio.c3.bubble", int'(if_b.bubble), 1);
        tick();
        @(negedge clk);
        chk("prio.c4.if_id_flush", int'(if_b.if_id_flush), 1);
        chk("prio.c4.pc_write", int'(if_b.pc_write), 1);
        chk("prio.c4.busy", int'(if_b.busy), 0);
        tick();
        @(negedge clk);
        chk("prio.c5.if_id_flush", int'(if_b.if_id_flush), 0);
        chk("prio.c5.bubble", int'(if_b.bubble), 0);
        chk("prio.c5.busy", int'(if_b.busy), 1);
        chk("prio.c5.pc_write", int'(if_b.pc_write), 1);
        tick();
        cur = idle;
        @(negedge clk);
        chk("prio.c6.busy", int'(if_b.busy), 0);
        chk("prio.c6.flush_events", int'(if_b.flush_events), 1);
        chk("prio.c6.stall_events", int'(if_b.stall_events), 1);

        // Reset pulse in the middle of a 3-cycle stall, no clock edge needed.
        tick();
        do_reset();
        cur = hzd;
        tick();
        cur = noisy;
        #2;
        chk("abort.pre.busy", int'(if_b.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort.pc_write", int'(if_b.pc_write), 1);
        chk("abort.if_id_write", int'(if_b.if_id_write), 1);
        chk("abort.bubble", int'(if_b.bubble), 0);
        chk("abort.if_id_flush", int'(if_b.if_id_flush), 0);
        chk("abort.busy", int'(if_b.busy), 0);
        chk("abort.forward_a", int'(if_b.forward_a), 0);
        chk("abort.forward_b", int'(if_b.forward_b), 0);
        chk("abort.stall_events", int'(if_b.stall_events), 0);
        tick();
        rst_n = 1'b1;
        cur = idle;
        @(negedge clk);
        chk("abort.after.busy", int'(if_b.busy), 0);
        chk("abort.after.pc_write", int'(if_b.pc_write), 1);

        // Counter saturation on the 4-bit instance (stays in RUN each cycle).
        tick();
        do_reset();
        cur = hzd;
        for (int k = 0; k < 14; k++) tick();
        chk("sat.pre", int'(if_a.stall_events), 14);
        for (int k = 0; k < 6; k++) tick();
        chk("sat.hold", int'(if_a.stall_events), 15);

        // Table of combinational vectors on the LOAD_STALL=1 instance.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cur = tbl[i].in;
            @(negedge clk);
            chk($sformatf("tbl%0d.pc_write", i), int'(if_a.pc_write), int'(tbl[i].pc));
            chk($sformatf("tbl%0d.bubble", i), int'(if_a.bubble), int'(tbl[i].bub));
            chk($sformatf("tbl%0d.forward_a", i), int'(if_a.forward_a), int'(tbl[i].fa));
            chk($sformatf("tbl%0d.forward_b", i), int'(if_a.forward_b), int'(tbl[i].fb));
            tick();
        end

        // Random traffic against the reference model.
        cur = idle;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            cur.mem_read_ex   = 1'($urandom_range(0, 1));
            cur.rt_ex         = 5'($urandom_range(0, 3));
            cur.rs_id         = 5'($urandom_range(0, 3));
            cur.rt_id         = 5'($urandom_range(0, 3));
            cur.use_rs_id     = 1'($urandom_range(0, 1));
            cur.use_rt_id     = 1'($urandom_range(0, 1));
            cur.redirect_id   = ($urandom_range(0, 3) == 0);
            cur.rs_ex         = 5'($urandom_range(0, 3));
            cur.rt_ex_src     = 5'($urandom_range(0, 3));
            cur.reg_write_mem = 1'($urandom_range(0, 1));
            cur.reg_write_wb  = 1'($urandom_range(0, 1));
            cur.rd_mem        = 5'($urandom_range(0, 3));
            cur.rd_wb         = 5'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 59) != 0);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    left[i] = 0; infl[i] = 0; se[i] = 0; fe[i] = 0;
                end
            end
            @(negedge clk);
            check_model(0);
            check_model(1);
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
